// File: rtl/geo_line_engine.sv
// Bresenham line rasteriser: one line command in, one pixel per clock out with full backpressure.
// Optional clip window discard is enabled by defining GEO_LINE_CLIP_EN.
module geo_line_engine #(
    parameter int CW = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic signed [CW-1:0] cmd_ax,
    input  logic signed [CW-1:0] cmd_ay,
    input  logic signed [CW-1:0] cmd_bx,
    input  logic signed [CW-1:0] cmd_by,
    input  logic signed [CW-1:0] clip_x0,
    input  logic signed [CW-1:0] clip_y0,
    input  logic signed [CW-1:0] clip_x1,
    input  logic signed [CW-1:0] clip_y1,
    input  logic                 abort,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic signed [CW-1:0] pix_x,
    output logic signed [CW-1:0] pix_y,
    output logic                 pix_last,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

    state_t state, state_next;

    logic signed [CW-1:0] cur_x, cur_y, end_x, end_y;
    logic signed [1:0]    sx, sy;
    logic signed [CW:0]   dx, dy;
    logic signed [CW+2:0] err, err_step;
    logic signed [CW+3:0] e2, dx_w, dy_w;
    logic signed [CW:0]   diff_x, diff_y, abs_x, abs_y;
    logic                 at_end, clipped, consume, step_x, step_y, done_next;

`ifdef GEO_LINE_CLIP_EN
    assign clipped = (state == RUN) &&
                     ((cur_x < clip_x0) || (cur_x > clip_x1) ||
                      (cur_y < clip_y0) || (cur_y > clip_y1));
`else
    logic unused_clip;
    assign unused_clip = ^{clip_x0, clip_y0, clip_x1, clip_y1};
    assign clipped     = 1'b0;
`endif

    assign at_end    = (cur_x == end_x) && (cur_y == end_y);
    assign pix_valid = (state == RUN) && !clipped;
    assign pix_last  = pix_valid && at_end;
    assign pix_x     = cur_x;
    assign pix_y     = cur_y;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign consume   = (state == RUN) && (clipped || pix_ready);

    // Deltas are one bit wider than the coordinates so a full-span line cannot wrap.
    always_comb begin
        diff_x   = {end_x[CW-1], end_x} - {cur_x[CW-1], cur_x};
        diff_y   = {end_y[CW-1], end_y} - {cur_y[CW-1], cur_y};
        abs_x    = (diff_x < 0) ? -diff_x : diff_x;
        abs_y    = (diff_y < 0) ? -diff_y : diff_y;
        e2       = {err, 1'b0};
        dx_w     = (CW+4)'(dx);
        dy_w     = (CW+4)'(dy);
        step_x   = (e2 >= dy_w);
        step_y   = (e2 <= dx_w);
        err_step = err + (step_x ? (CW+3)'(dy) : '0) + (step_y ? (CW+3)'(dx) : '0);
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) state_next = SETUP;
            end
            SETUP: begin
                if (abort) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort || (consume && at_end)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            cur_x <= '0;
            cur_y <= '0;
            end_x <= '0;
            end_y <= '0;
            sx    <= '0;
            sy    <= '0;
            dx    <= '0;
            dy    <= '0;
            err   <= '0;
        end else begin
            state <= state_next;
            done  <= done_next;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_x <= cmd_ax;
                        cur_y <= cmd_ay;
                        end_x <= cmd_bx;
                        end_y <= cmd_by;
                        sx    <= (cmd_bx > cmd_ax) ? 2'sd1 : ((cmd_bx < cmd_ax) ? -2'sd1 : 2'sd0);
                        sy    <= (cmd_by > cmd_ay) ? 2'sd1 : ((cmd_by < cmd_ay) ? -2'sd1 : 2'sd0);
                    end
                end
                SETUP: begin
                    dx  <= abs_x;
                    dy  <= -abs_y;
                    err <= (CW+3)'(abs_x) - (CW+3)'(abs_y);
                end
                RUN: begin
                    if (consume && !at_end && !abort) begin
                        err <= err_step;
                        if (step_x) cur_x <= cur_x + CW'(sx);
                        if (step_y) cur_y <= cur_y + CW'(sy);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_geo_line_engine.sv
// Self-checking bench for geo_line_engine: directed and randomized lines against a Bresenham reference list.
module tb_geo_line_engine;

    localparam int CW     = 12;
    localparam int BUDGET = 6000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cmd_valid, cmd_ready, abort;
    logic signed [CW-1:0] cmd_ax, cmd_ay, cmd_bx, cmd_by;
    logic signed [CW-1:0] clip_x0, clip_y0, clip_x1, clip_y1;
    logic                 pix_valid, pix_ready, pix_last, busy, done;
    logic signed [CW-1:0] pix_x, pix_y;

    geo_line_engine #(.CW(CW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ax(cmd_ax), .cmd_ay(cmd_ay), .cmd_bx(cmd_bx), .cmd_by(cmd_by),
        .clip_x0(clip_x0), .clip_y0(clip_y0), .clip_x1(clip_x1), .clip_y1(clip_y1),
        .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int cap_x[$], cap_y[$], cap_l[$];
    int exp_x[$], exp_y[$], exp_l[$];
    int first_valid, done_cycle, last_hs, stall_err, busy_k1;
    int valid_at_done, ready_at_done;
    bit timed_out;
    int win_x0, win_y0, win_x1, win_y1;

    // Reference: walk the ideal Bresenham path with integers, keeping pixels the window lets through.
    task automatic model_line(input int ax, input int ay, input int bx, input int by);
        int x, y, ddx, ddy, sxm, sym, e, e2m;
        bit keep;
        exp_x.delete(); exp_y.delete(); exp_l.delete();
        x = ax; y = ay;
        ddx = (bx > ax) ? bx - ax : ax - bx;
        ddy = (by > ay) ? ay - by : by - ay;
        sxm = (bx > ax) ? 1 : ((bx < ax) ? -1 : 0);
        sym = (by > ay) ? 1 : ((by < ay) ? -1 : 0);
        e = ddx + ddy;
        forever begin
            keep = 1'b1;
`ifdef GEO_LINE_CLIP_EN
            keep = (x >= win_x0) && (x <= win_x1) && (y >= win_y0) && (y <= win_y1);
`endif
            if (keep) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
                exp_l.push_back((x == bx && y == by) ? 1 : 0);
            end
            if (x == bx && y == by) break;
            e2m = 2 * e;
            if (e2m >= ddy) begin e += ddy; x += sxm; end
            if (e2m <= ddx) begin e += ddx; y += sym; end
        end
    endtask

    function automatic int first_diff();
        if (cap_x.size() != exp_x.size()) return -2;
        foreach (cap_x[i])
            if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_l[i] != exp_l[i]) return i;
        return -1;
    endfunction

    task automatic set_window(input int x0, input int y0, input int x1, input int y1);
        win_x0 = x0; win_y0 = y0; win_x1 = x1; win_y1 = y1;
        clip_x0 = x0[CW-1:0]; clip_y0 = y0[CW-1:0];
        clip_x1 = x1[CW-1:0]; clip_y1 = y1[CW-1:0];
    endtask

    // Issues one command from a negedge and records every handshaken pixel until done.
    // ready_mode: 0 always ready, 1 random, 2 low for three clocks after the second pixel.
    // abort_at: cycle index after accept to raise abort (0 = together with the command, <0 never).
    task automatic drive_line(input int ax, input int ay, input int bx, input int by,
                              input int ready_mode, input int abort_at);
        int  w, hs, hold, px, py, pl;
        bit  rdy, prev_stall;
        cap_x.delete(); cap_y.delete(); cap_l.delete();
        first_valid = -1; done_cycle = -1; last_hs = -1; stall_err = 0; timed_out = 1'b0;
        busy_k1 = 0; valid_at_done = -1; ready_at_done = -1;
        hs = 0; hold = 0; prev_stall = 1'b0; px = 0; py = 0; pl = 0;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        cmd_ax = ax[CW-1:0]; cmd_ay = ay[CW-1:0];
        cmd_bx = bx[CW-1:0]; cmd_by = by[CW-1:0];
        cmd_valid = 1'b1;
        abort = (abort_at == 0);
        timed_out = 1'b1;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_valid = 1'b0;
                busy_k1   = busy;
            end
            abort = (k == abort_at);
            if (prev_stall && (!pix_valid || int'(pix_x) != px || int'(pix_y) != py || int'(pix_last) != pl))
                stall_err++;
            if (done) begin
                done_cycle    = k;
                valid_at_done = pix_valid;
                ready_at_done = cmd_ready;
                timed_out     = 1'b0;
                break;
            end
            if (pix_valid && first_valid < 0) first_valid = k;
            if (ready_mode == 0)                     rdy = 1'b1;
            else if (ready_mode == 1)                rdy = ($urandom_range(3) != 0);
            else if (hold > 0) begin                 rdy = 1'b0; hold--; end
            else                                     rdy = 1'b1;
            pix_ready = rdy;
            if (pix_valid && rdy && !abort) begin
                cap_x.push_back(int'(pix_x));
                cap_y.push_back(int'(pix_y));
                cap_l.push_back(int'(pix_last));
                last_hs = k;
                hs++;
                if (ready_mode == 2 && hs == 2) hold = 3;
            end
            prev_stall = pix_valid && !rdy;
            px = int'(pix_x); py = int'(pix_y); pl = int'(pix_last);
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, pix_valid, pix_last, busy, done} !== 5'b10000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b want 10000", {cmd_ready, pix_valid, pix_last, busy, done});
        end
        n_cmp++;
        if (pix_x !== '0 || pix_y !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_xy: got (%0d,%0d) want (0,0)", pix_x, pix_y);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_line();
        model_line(0, 0, 5, 2);
        drive_line(0, 0, 5, 2, 0, -1);
        n_cmp++;
        if (first_diff() != -1) begin
            n_fail++;
            $display("[TB] FAIL basic_pixels: diff at %0d, got %0d pixels want %0d", first_diff(), cap_x.size(), exp_x.size());
        end
        n_cmp++;
        if (busy_k1 != 1 || first_valid != 2) begin
            n_fail++;
            $display("[TB] FAIL basic_latency: busy@1=%0d first_valid=%0d want 1 and 2", busy_k1, first_valid);
        end
        n_cmp++;
        if (done_cycle != 8) begin
            n_fail++;
            $display("[TB] FAIL basic_done: got cycle %0d want 8", done_cycle);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_done_pulse: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_single_point();
        model_line(7, -3, 7, -3);
        drive_line(7, -3, 7, -3, 0, -1);
        n_cmp++;
        if (first_diff() != -1 || cap_x.size() != 1 || cap_l[0] != 1) begin
            n_fail++;
            $display("[TB] FAIL single_point: got %0d pixels want 1 (7,-3) last", cap_x.size());
        end
        n_cmp++;
        if (done_cycle != 3) begin
            n_fail++;
            $display("[TB] FAIL single_done: got cycle %0d want 3", done_cycle);
        end
    endtask

    task automatic test_full_span();
        model_line(-2048, -2048, 2047, 2047);
        drive_line(-2048, -2048, 2047, 2047, 0, -1);
        n_cmp++;
        if (first_diff() != -1 || cap_x.size() != 4096) begin
            n_fail++;
            $display("[TB] FAIL full_span: got %0d pixels (diff %0d) want 4096", cap_x.size(), first_diff());
        end
        n_cmp++;
        if (cap_x.size() == 0 || cap_x[$] != 2047 || cap_y[$] != 2047 || done_cycle != 4098) begin
            n_fail++;
            $display("[TB] FAIL full_span_end: done cycle %0d want 4098, last (2047,2047)", done_cycle);
        end
    endtask

    task automatic test_backpressure();
        model_line(10, 10, 0, 4);
        drive_line(10, 10, 0, 4, 2, -1);
        n_cmp++;
        if (first_diff() != -1 || cap_x.size() != 11) begin
            n_fail++;
            $display("[TB] FAIL bp_pixels: got %0d pixels (diff %0d) want 11", cap_x.size(), first_diff());
        end
        n_cmp++;
        if (stall_err != 0 || cap_x.size() < 3 || cap_x[2] != 8 || cap_y[2] != 9) begin
            n_fail++;
            $display("[TB] FAIL bp_hold: stall errors %0d, third pixel wrong, want 0 errors and (8,9)", stall_err);
        end
        n_cmp++;
        if (done_cycle != last_hs + 1) begin
            n_fail++;
            $display("[TB] FAIL bp_done: got cycle %0d want %0d", done_cycle, last_hs + 1);
        end
    endtask

    task automatic test_abort();
        drive_line(0, 0, 100, 0, 0, 4);
        n_cmp++;
        if (done_cycle != 5 || valid_at_done != 0 || ready_at_done != 1) begin
            n_fail++;
            $display("[TB] FAIL abort_timing: done=%0d valid=%0d ready=%0d want 5 0 1", done_cycle, valid_at_done, ready_at_done);
        end
        n_cmp++;
        if (cap_x.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL abort_pixels: got %0d want 2", cap_x.size());
        end
        model_line(3, 4, 6, 5);
        drive_line(3, 4, 6, 5, 0, -1);
        n_cmp++;
        if (first_valid != 2 || first_diff() != -1) begin
            n_fail++;
            $display("[TB] FAIL abort_restart: first_valid %0d diff %0d want 2 -1", first_valid, first_diff());
        end
        // abort while idle must be ignored and the command taken
        model_line(-5, 2, -1, -6);
        drive_line(-5, 2, -1, -6, 0, 0);
        n_cmp++;
        if (first_diff() != -1 || done_cycle != last_hs + 1) begin
            n_fail++;
            $display("[TB] FAIL abort_idle: got %0d pixels want %0d", cap_x.size(), exp_x.size());
        end
    endtask

    task automatic test_back_to_back();
        int ax, ay, bx, by;
        for (int n = 0; n < 4; n++) begin
            ax = int'($urandom_range(60)) - 30; ay = int'($urandom_range(60)) - 30;
            bx = int'($urandom_range(60)) - 30; by = int'($urandom_range(60)) - 30;
            model_line(ax, ay, bx, by);
            drive_line(ax, ay, bx, by, 0, -1);
            n_cmp++;
            if (first_diff() != -1 || first_valid != 2) begin
                n_fail++;
                $display("[TB] FAIL b2b_line%0d: diff %0d first_valid %0d want -1 2", n, first_diff(), first_valid);
            end
        end
    endtask

    task automatic test_random();
        int ax, ay, bx, by;
        for (int n = 0; n < 30; n++) begin
            ax = int'($urandom_range(100)) - 50; ay = int'($urandom_range(100)) - 50;
            bx = int'($urandom_range(100)) - 50; by = int'($urandom_range(100)) - 50;
            if (n == 29) begin ax = 2047; ay = -2048; bx = -2048; by = 1000; end
            set_window(int'($urandom_range(40)) - 40, int'($urandom_range(40)) - 40,
                       int'($urandom_range(40)),      int'($urandom_range(40)));
            model_line(ax, ay, bx, by);
            drive_line(ax, ay, bx, by, 1, -1);
            n_cmp++;
            if (timed_out || first_diff() != -1 || stall_err != 0) begin
                n_fail++;
                $display("[TB] FAIL random_line%0d (%0d,%0d)->(%0d,%0d): got %0d pixels want %0d, stall errors %0d, timeout %0d",
                         n, ax, ay, bx, by, cap_x.size(), exp_x.size(), stall_err, timed_out);
            end
        end
        set_window(-2048, -2048, 2047, 2047);
    endtask

    task automatic test_reset_midline();
        cmd_ax = 12'sd0; cmd_ay = 12'sd0; cmd_bx = 12'sd200; cmd_by = 12'sd50;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        pix_ready = 1'b1;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({cmd_ready, pix_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL reset_midline: got %b want 100", {cmd_ready, pix_valid, busy});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

`ifdef GEO_LINE_CLIP_EN
    task automatic test_clip();
        set_window(0, 0, 3, 3);
        model_line(-2, 0, 5, 0);
        drive_line(-2, 0, 5, 0, 0, -1);
        n_cmp++;
        if (first_diff() != -1 || cap_x.size() != 4 || first_valid != 4) begin
            n_fail++;
            $display("[TB] FAIL clip_pixels: got %0d first at %0d want 4 at 4", cap_x.size(), first_valid);
        end
        n_cmp++;
        if (done_cycle != 10) begin
            n_fail++;
            $display("[TB] FAIL clip_done: got cycle %0d want 10", done_cycle);
        end
        set_window(-2048, -2048, 2047, 2047);
    endtask
`endif

    initial begin
        cmd_valid = 1'b0; abort = 1'b0; pix_ready = 1'b0;
        cmd_ax = '0; cmd_ay = '0; cmd_bx = '0; cmd_by = '0;
`ifdef GEO_LINE_CLIP_EN
        set_window(-2048, -2048, 2047, 2047);
`else
        set_window(5, 5, 6, 6);
`endif
        test_reset();
        test_basic_line();
        test_single_point();
        test_full_span();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_midline();
`ifdef GEO_LINE_CLIP_EN
        test_clip();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/geo_line_engine.md
# geo_line_engine

Parametrised Bresenham line rasteriser for the geometry writer pipeline. It accepts one line command at a time over a valid/ready handshake. It emits one pixel coordinate per clock over a second valid/ready handshake with full backpressure, and can optionally discard pixels outside a clip window. Its pixel output feeds the pixel writer directly.

## Interface
- `CW`, default 12: signed coordinate width in bits.
- `clk` in, 1: pixel clock.
- `reset` in, 1: asynchronous, active-high.
- `cmd_valid` in, 1: line command present on `cmd_ax`/`cmd_ay`/`cmd_bx`/`cmd_by`.
- `cmd_ready` out, 1: engine can accept a command.
- `cmd_ax`, `cmd_ay`, `cmd_bx`, `cmd_by` in, CW each: signed start point (a) and end point (b).
- `clip_x0`, `clip_y0`, `clip_x1`, `clip_y1` in, CW each: signed inclusive clip window. Sampled live; must be held stable while `busy`.
- `abort` in, 1: synchronous cancel of the current line.
- `pix_valid` out, 1: `pix_x`/`pix_y`/`pix_last` are valid.
- `pix_ready` in, 1: downstream accepts the pixel.
- `pix_x`, `pix_y` out, CW each: signed pixel coordinate.
- `pix_last` out, 1: the presented pixel is the geometric endpoint b.
- `busy` out, 1: a line is in progress.
- `done` out, 1: one-cycle pulse when a line finishes or is aborted.

## Operation
- FSM states:
  - IDLE: `cmd_ready` = 1. `cmd_valid` = 1 latches a, b, and the direction signs `sx`, `sy` (each +1, 0 or −1), then moves to SETUP.
  - SETUP: computes `dx` = |bx−ax| and `dy` = −|by−ay`|, both CW+1 bits. Sets `err` = dx+dy, CW+3 bits signed. Moves to RUN.
  - RUN: presents the current (x, y). The pixel is consumed when `pix_valid`&&`pix_ready`, or immediately when the pixel is clipped.
- Consuming the pixel at b: return to IDLE and pulse `done` on the next cycle.
- Consuming any other pixel: step one position.
  - e2 = 2·err.
  - If e2 ≥ dy: err += dy, x += sx.
  - If e2 ≤ dx: err += dx, y += sy.
  - Both updates may apply in the same step and use the pre-step err.
- Pixels emitted per line = max(|dx|, |dy|)+1, in order a → b.
- Single point (a == b): exactly one pixel with `pix_last` = 1.
- When `pix_valid`=1 and `pix_ready`=0, `pix_x`, `pix_y` and `pix_last` hold stable and no step occurs.
- `abort` in SETUP or RUN has priority over everything:
  - Next cycle: IDLE, `pix_valid` = 0, `done` pulses.
  - Pending pixels are dropped.
  - `abort` in IDLE is ignored, and a `cmd_valid` in the same cycle is accepted.
- A command may be accepted in the same cycle that `done` is high (the state is already IDLE).
- Asynchronous `reset` mid-line returns to IDLE immediately and discards the line.
- No internal overflow for any CW-bit inputs, including the full span −2^(CW−1) to 2^(CW−1)−1.

## Timing
- Reset values:
  - `cmd_ready` = 1; `pix_valid`, `pix_last`, `busy` and `done` = 0.
  - `pix_x`, `pix_y` = 0; state = IDLE.
- Command accepted at rising edge N: `busy` = 1 from N+1, first `pix_valid` at N+2.
- Throughput: one pixel per clock while `pix_ready` = 1.
- `done` is a registered single-cycle pulse in the cycle after the final handshake; `busy` = 0 in that same cycle.
- `cmd_ready` = (state == IDLE), registered.

## Configuration
- `GEO_LINE_CLIP_EN` defined:
  - In RUN, a pixel outside [clip_x0..clip_x1]×[clip_y0..clip_y1] is stepped past in one clock with `pix_valid` = 0 and no handshake.
  - `pix_last` is only seen if b is inside the window.
  - `done` always pulses.
- `GEO_LINE_CLIP_EN` undefined: the clip ports are ignored and every pixel is presented.

## Test plan
- CW=12, (0,0)→(5,2), `pix_ready`=1 → (0,0), (1,0), (2,1), (3,1), (4,2), (5,2) on consecutive clocks; `pix_last` only on (5,2); `done` one clock later; first pixel 2 clocks after accept.
- (7,−3)→(7,−3) → a single pixel (7,−3) with `pix_last`=1, then `done`.
- (−2048,−2048)→(2047,2047) → 4096 pixels on the diagonal, last (2047,2047); no wrap.
- (10,10)→(0,4) with `pix_ready` low for 3 clocks after the 2nd pixel → the 3rd pixel (8,9) is held stable; 11 pixels total, none lost or duplicated.
- `abort` on the 3rd RUN cycle of (0,0)→(100,0) → `pix_valid` = 0 next clock, `done` pulse, `cmd_ready` = 1. A new command issued the same cycle `done` is high starts 2 clocks later.
- With `GEO_LINE_CLIP_EN` and clip 0..3×0..3, (−2,0)→(5,0) → only (0,0)..(3,0) emitted, no `pix_last`, `done` 8 RUN clocks after entering RUN.
